// File: rtl/sha3_block_loader.sv
// Gathers 64-bit AXI-Stream lanes into one Keccak rate block and presents the 5x5 state
// to the padding stage, adding the trailing all-zero block when a message ends on a rate boundary.
module sha3_block_loader (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [63:0]            TDATA,
    input  logic                   TVALID,
    output logic                   TREADY,
    input  logic                   TLAST,
    input  logic [1:0]             TUSER,
    output logic                   M_VALID,
    input  logic                   M_READY,
    output logic                   M_LAST,
    output logic [1:0]             M_MODE,
    output logic [4:0]             M_LANES,
    output logic [0:4][0:4][63:0]  D_out
);
    typedef enum logic [1:0] {FILL, HOLD, ZERO_LAST} state_t;

    state_t                  r_state;
    logic [4:0]              r_cnt;
    logic [2:0]              r_row;
    logic [2:0]              r_col;
    logic                    r_pending_last;
    logic                    r_tready;
    logic                    r_mvalid;
    logic                    r_mlast;
    logic [1:0]              r_mode;
    logic [4:0]              r_lanes;
    logic [0:4][0:4][63:0]   r_d;

    logic [1:0] w_mode;
    logic       w_beat;
    logic       w_rate_end;
    logic       w_done;
    logic       w_exact;

    function automatic logic [4:0] rate_of(input logic [1:0] m);
        case (m)
            2'd0:    rate_of = 5'd18;
            2'd1:    rate_of = 5'd17;
            2'd2:    rate_of = 5'd13;
            default: rate_of = 5'd9;
        endcase
    endfunction

    // The mode of a block is whatever TUSER says on its first beat.
    always_comb begin
        w_mode     = (r_cnt == 5'd0) ? TUSER : r_mode;
        w_beat     = TVALID & r_tready & (r_state == FILL);
        w_rate_end = (r_cnt == rate_of(w_mode) - 5'd1);
        w_done     = w_rate_end | TLAST;
        w_exact    = w_rate_end & TLAST;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state        <= FILL;
            r_cnt          <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_pending_last <= 1'b0;
            r_tready       <= 1'b0;
            r_mvalid       <= 1'b0;
            r_mlast        <= 1'b0;
            r_mode         <= '0;
            r_lanes        <= '0;
            r_d            <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    r_tready <= 1'b1;
                    if (w_beat) begin
                        r_d[r_row][r_col] <= TDATA;
                        r_mode            <= w_mode;
                        if (w_done) begin
                            r_state        <= HOLD;
                            r_tready       <= 1'b0;
                            r_mvalid       <= 1'b1;
                            r_lanes        <= r_cnt + 5'd1;
                            r_mlast        <= TLAST & ~w_exact;
                            r_pending_last <= w_exact;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                            // beat k lands in row k mod 5, column k div 5
                            if (r_row == 3'd4) begin
                                r_row <= '0;
                                r_col <= r_col + 3'd1;
                            end else begin
                                r_row <= r_row + 3'd1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (M_READY) begin
                        r_d <= '0;
                        if (r_pending_last) begin
                            r_state        <= ZERO_LAST;
                            r_pending_last <= 1'b0;
                            r_lanes        <= '0;
                            r_mlast        <= 1'b1;
                        end else begin
                            r_state  <= FILL;
                            r_mvalid <= 1'b0;
                            r_tready <= 1'b1;
                            r_cnt    <= '0;
                            r_row    <= '0;
                            r_col    <= '0;
                        end
                    end
                end
                ZERO_LAST: begin
                    if (M_READY) begin
                        r_state  <= FILL;
                        r_mvalid <= 1'b0;
                        r_tready <= 1'b1;
                        r_cnt    <= '0;
                        r_row    <= '0;
                        r_col    <= '0;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign TREADY  = r_tready;
    assign M_VALID = r_mvalid;
    assign M_LAST  = r_mlast;
    assign M_MODE  = r_mode;
    assign M_LANES = r_lanes;
    assign D_out   = r_d;
endmodule

// File: tb/tb_sha3_block_loader.sv
// Directed bench for sha3_block_loader: message table plus hand-written reset,
// backpressure and mid-block-abort sequences.
module tb_sha3_block_loader;
    logic                  ACLK = 1'b0;
    logic                  ARESETN = 1'b0;
    logic [63:0]           TDATA = '0;
    logic                  TVALID = 1'b0;
    logic                  TREADY;
    logic                  TLAST = 1'b0;
    logic [1:0]            TUSER = '0;
    logic                  M_VALID;
    logic                  M_READY = 1'b0;
    logic                  M_LAST;
    logic [1:0]            M_MODE;
    logic [4:0]            M_LANES;
    logic [0:4][0:4][63:0] D_out;

    int errs = 0;
    int checks = 0;

    sha3_block_loader dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .TDATA(TDATA), .TVALID(TVALID), .TREADY(TREADY),
        .TLAST(TLAST), .TUSER(TUSER), .M_VALID(M_VALID), .M_READY(M_READY), .M_LAST(M_LAST),
        .M_MODE(M_MODE), .M_LANES(M_LANES), .D_out(D_out)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0] u0;
        logic [1:0] u1;
        int         nb;
        int         nblk;
        int         lanes0;
        logic       last0;
        logic [1:0] mode0;
        int         lanes1;
        logic       last1;
        logic [1:0] mode1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] word(input int msg, input int j);
        word = (64'(msg) << 32) | 64'(j + 1);
    endfunction

    // Lane k of the block must hold beat start+k for k<lanes, zero elsewhere.
    task automatic chk_data(input string nm, input int msg, input int start, input int lanes);
        int bad = 0;
        logic [63:0] exp;
        for (int k = 0; k < 25; k++) begin
            exp = (k < lanes) ? word(msg, start + k) : 64'd0;
            if (D_out[k % 5][k / 5] !== exp) bad++;
        end
        chk(nm, 64'(bad), 64'd0);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l, input logic [1:0] u);
        int n = 0;
        TVALID = 1'b1; TDATA = d; TLAST = l; TUSER = u;
        @(negedge ACLK);
        while (!TREADY && n < 300) begin
            n++;
            @(negedge ACLK);
        end
        if (n >= 300) chk("tready_timeout", 64'(n), 64'd0);
        @(posedge ACLK);
        #1;
        TVALID = 1'b0; TLAST = 1'b0;
    endtask

    task automatic send_msg(input int msg, input int nb, input logic [1:0] u0, input logic [1:0] u1);
        for (int j = 0; j < nb; j++)
            send_beat(word(msg, j), j == nb - 1, (j == 0) ? u0 : u1);
    endtask

    // Expects M_READY held high by the caller; consumes one block.
    task automatic get_block(input int msg, input int start, input int lanes,
                             input logic last, input logic [1:0] mode);
        int n = 0;
        @(negedge ACLK);
        while (!M_VALID && n < 300) begin
            n++;
            @(negedge ACLK);
        end
        chk("mvalid_timeout", 64'(n >= 300), 64'd0);
        chk("lanes", 64'(M_LANES), 64'(lanes));
        chk("last", 64'(M_LAST), 64'(last));
        chk("mode", 64'(M_MODE), 64'(mode));
        chk("tready_hold", 64'(TREADY), 64'd0);
        chk_data("data", msg, start, lanes);
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        logic [0:4][0:4][63:0] snap;
        vecs[0] = '{u0:2'd3, u1:2'd3, nb:5,  nblk:1, lanes0:5,  last0:1'b1, mode0:2'd3, lanes1:0, last1:1'b0, mode1:2'd0};
        vecs[1] = '{u0:2'd1, u1:2'd1, nb:20, nblk:2, lanes0:17, last0:1'b0, mode0:2'd1, lanes1:3, last1:1'b1, mode1:2'd1};
        vecs[2] = '{u0:2'd3, u1:2'd3, nb:9,  nblk:2, lanes0:9,  last0:1'b0, mode0:2'd3, lanes1:0, last1:1'b1, mode1:2'd3};
        vecs[3] = '{u0:2'd0, u1:2'd2, nb:18, nblk:2, lanes0:18, last0:1'b0, mode0:2'd0, lanes1:0, last1:1'b1, mode1:2'd0};
        vecs[4] = '{u0:2'd2, u1:2'd2, nb:1,  nblk:1, lanes0:1,  last0:1'b1, mode0:2'd2, lanes1:0, last1:1'b0, mode1:2'd0};
        vecs[5] = '{u0:2'd2, u1:2'd1, nb:14, nblk:2, lanes0:13, last0:1'b0, mode0:2'd2, lanes1:1, last1:1'b1, mode1:2'd1};

        // Reset with garbage on the inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge ACLK); #1;
            TDATA = {$urandom, $urandom}; TVALID = 1'b1; TLAST = 1'($urandom);
            TUSER = 2'($urandom); M_READY = 1'($urandom);
        end
        @(negedge ACLK);
        chk("rst_ctrl", 64'({TREADY, M_VALID, M_LAST, M_MODE, M_LANES}), 64'd0);
        chk("rst_data", 64'(D_out != '0), 64'd0);
        @(posedge ACLK); #1;
        TVALID = 1'b0; TLAST = 1'b0; M_READY = 1'b1; ARESETN = 1'b1;
        @(negedge ACLK);
        chk("tready_pre", 64'(TREADY), 64'd0);
        @(negedge ACLK);
        chk("tready_rise", 64'(TREADY), 64'd1);
        @(posedge ACLK); #1;

        // Message table
        for (int i = 0; i < 6; i++) begin
            fork
                send_msg(i, vecs[i].nb, vecs[i].u0, vecs[i].u1);
                begin
                    get_block(i, 0, vecs[i].lanes0, vecs[i].last0, vecs[i].mode0);
                    if (vecs[i].nblk == 2)
                        get_block(i, vecs[i].lanes0, vecs[i].lanes1, vecs[i].last1, vecs[i].mode1);
                end
            join
        end

        // Backpressure: 18-lane exact fill held for 10 cycles
        M_READY = 1'b0;
        send_msg(7, 18, 2'd0, 2'd2);
        @(negedge ACLK);
        chk("bp_valid", 64'(M_VALID), 64'd1);
        chk("bp_mode", 64'(M_MODE), 64'd0);
        chk("bp_lanes", 64'(M_LANES), 64'd18);
        snap = D_out;
        chk_data("bp_data", 7, 0, 18);
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            chk("bp_stall", 64'({M_VALID, TREADY, D_out == snap}), 64'b101);
        end
        @(posedge ACLK); #1;
        M_READY = 1'b1;
        @(negedge ACLK);
        chk("bp_hold_last", 64'({M_VALID, M_LANES}), {58'd0, 1'b1, 5'd18});
        @(negedge ACLK);
        chk("bp_zero", 64'({M_VALID, M_LAST, TREADY, M_LANES, M_MODE}), {55'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0});
        chk("bp_zero_data", 64'(D_out != '0), 64'd0);
        @(negedge ACLK);
        chk("bp_turn", 64'({M_VALID, TREADY}), 64'b01);

        // Abort a block after 4 beats
        @(posedge ACLK); #1;
        for (int j = 0; j < 4; j++) send_beat(word(8, j), 1'b0, 2'd3);
        ARESETN = 1'b0;
        #1;
        chk("abort_ctrl", 64'({TREADY, M_VALID, M_LAST, M_MODE, M_LANES}), 64'd0);
        chk("abort_data", 64'(D_out != '0), 64'd0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        fork
            send_msg(9, 2, 2'd3, 2'd3);
            get_block(9, 0, 2, 1'b1, 2'd3);
        join

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/sha3_block_loader.md
# sha3_block_loader

Collects 64-bit AXI-Stream message words into one Keccak rate block and hands the assembled 5x5x64 state array, plus last-block flag and mode, to the downstream padding stage. It sits between the AXI-Stream slave port of the SHA3 core and the padding block. The lane count per block is selected by the hash mode. It is also responsible for emitting the extra all-zero final block when a message ends exactly on a rate boundary.

## Interface
- Parameters: none; lane width fixed at 64, state fixed at 5x5 lanes.
- ACLK  in  1  single clock; all state updates on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- TDATA  in  64  message word; one full lane per beat, little-endian within the lane.
- TVALID  in  1  slave beat valid.
- TREADY  out  1  slave beat ready; a beat transfers when TVALID & TREADY.
- TLAST  in  1  marks the final beat of a message.
- TUSER  in  2  mode: 0=SHA3-224 (18 lanes), 1=SHA3-256 (17), 2=SHA3-384 (13), 3=SHA3-512 (9).
- M_VALID  out  1  assembled block valid.
- M_READY  in  1  downstream accepts the block when M_VALID & M_READY.
- M_LAST  out  1  block is the final block of the message; drives padding TLAST.
- M_MODE  out  2  mode latched for this block; drives padding TUSER.
- M_LANES  out  5  number of message lanes written into this block (0..18).
- D_out  out  [0:4][0:4][63:0]  assembled state; beat k written to D_out[k mod 5][k div 5].

## Operation
- States: FILL, HOLD, ZERO_LAST.
- FILL: TREADY=1. Each accepted beat writes TDATA to lane cnt, then cnt++. The first beat of a block (cnt==0) latches TUSER into M_MODE. TUSER on later beats is ignored. Unwritten lanes stay 0.
- Block completes on an accepted beat with cnt == RATE(mode)-1, or on one with TLAST=1, whichever comes first. The next state is HOLD. M_LANES = cnt+1. M_LAST = TLAST unless the exact-fill case applies.
- Exact fill: if TLAST=1 and cnt == RATE-1 on the same beat, the block goes out with M_LAST=0 and the pending_last flag is set.
- HOLD: M_VALID=1, TREADY=0. D_out, M_LAST, M_MODE and M_LANES stay stable until the handshake.
  - On M_READY with pending_last=1: clear D_out, set M_LANES=0, clear pending_last, go to ZERO_LAST.
  - On M_READY otherwise: clear D_out, set cnt=0, go to FILL.
- ZERO_LAST: M_VALID=1, M_LAST=1, M_MODE unchanged, D_out all zero, TREADY=0. On M_READY, go to FILL with cnt=0.
- The padding stage inserts the padding bits into the final block. This block never does.
- cnt is 5 bits. The RATE lookup is a 2-bit-indexed constant, so cnt never exceeds 17.

## Timing
- Reset (ARESETN=0, asynchronous): state=FILL, cnt=0, pending_last=0, TREADY=0, M_VALID=0, M_LAST=0, M_MODE=0, M_LANES=0, D_out all 0.
- TREADY is registered. It rises on the first ACLK edge after ARESETN deasserts.
- Latency: M_VALID rises one cycle after the completing beat is accepted. TREADY falls in that same cycle.
- TREADY is registered, so it still reads 1 in the cycle the completing beat transfers. It is 0 in every cycle where M_VALID=1.
- After the M_READY handshake, M_VALID=0 and TREADY=1 on the next cycle (one-cycle turnaround). ZERO_LAST is the exception: M_VALID stays 1 into it, and TREADY stays 0.
- Sustained throughput in FILL is one beat per cycle.
- M_READY sampled while M_VALID=0 has no effect.
- Reset asserted mid-block or in HOLD discards the partial block immediately. No output is produced for it.

## Test plan
- Reset: hold ARESETN=0 with random inputs -> all outputs 0, TREADY=0. TREADY=1 one edge after release.
- Short message: TUSER=3, 5 beats of data 1..5, TLAST on beat 5, M_READY=1 -> one block with M_LANES=5, M_LAST=1, M_MODE=3, D_out[k mod 5][k div 5]=k+1 for k<5, all other lanes 0.
- Multi-block: TUSER=1, 20 beats, TLAST on beat 20 -> block 1 has M_LANES=17, M_LAST=0; block 2 has M_LANES=3, M_LAST=1, carrying beats 18..20 in lanes [0][0], [1][0], [2][0].
- Exact fill: TUSER=3, 9 beats, TLAST on beat 9 -> block 1 has M_LANES=9, M_LAST=0; then an all-zero block with M_LANES=0, M_LAST=1, M_MODE=3. TREADY stays 0 until the second handshake.
- Backpressure and mode change: TUSER=0, TUSER toggled to 2 after beat 1, 18 beats, M_READY=0 for 10 cycles after M_VALID -> M_MODE=0 and M_LANES=18. D_out stays unchanged across the stall, TREADY=0 throughout, and the block releases on the first M_READY cycle.
- Mid-block reset: assert ARESETN=0 after 4 of 9 beats -> outputs clear that cycle. A following 2-beat TLAST message yields M_LANES=2 with no residue from the aborted beats.
